// File: rtl/cdc_toggle_monitor.sv
// cdc_toggle_monitor: turns a synchronised toggle level into event pulses,
// counts them over a fixed window of Bclk cycles and flags a stalled source.
module cdc_toggle_monitor #(
  parameter int CNT_W        = 16,
  parameter int WIN_CYCLES   = 1000,
  parameter int STALL_CYCLES = 64,
  parameter bit CONTINUOUS   = 1'b0
) (
  input  logic             Bclk,
  input  logic             reset,
  input  logic             Din,
  input  logic             start,
  output logic             edge_pulse,
  output logic             busy,
  output logic [CNT_W-1:0] count,
  output logic             count_valid,
  output logic             overflow,
  output logic             stalled
);

  localparam int WW = $clog2(WIN_CYCLES);
  localparam int IW = $clog2(STALL_CYCLES + 1);
  localparam logic [CNT_W-1:0] ACC_MAX  = '1;
  localparam logic [WW-1:0]    WIN_LAST = WW'(WIN_CYCLES - 1);
  localparam logic [IW-1:0]    STALL_N  = IW'(STALL_CYCLES);

  typedef enum logic [1:0] {IDLE, MEASURE, DONE} state_t;

  state_t           state, state_nxt;
  logic             din_q, primed;
  logic             win_load;
  logic [WW-1:0]    win_cnt;
  logic [CNT_W-1:0] acc, acc_nxt;
  logic [IW-1:0]    idle_cnt, idle_nxt;

  // Edge detector; the first edge after reset only primes din_q.
  always_ff @(posedge Bclk or negedge reset) begin
    if (!reset) begin
      din_q      <= 1'b0;
      primed     <= 1'b0;
      edge_pulse <= 1'b0;
    end else begin
      din_q      <= Din;
      primed     <= 1'b1;
      edge_pulse <= primed & (Din != din_q);
    end
  end

  // State register.
  always_ff @(posedge Bclk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; win_load marks the edge that opens a new window.
  always_comb begin
    state_nxt = state;
    win_load  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = MEASURE;
          win_load  = 1'b1;
        end
      end
      MEASURE: begin
        if (win_cnt == '0) state_nxt = DONE;
      end
      DONE: begin
        if (CONTINUOUS) begin
          state_nxt = MEASURE;
          win_load  = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy    = (state == MEASURE);
  assign acc_nxt = (edge_pulse && (acc != ACC_MAX)) ? acc + CNT_W'(1) : acc;

  // Window counter, saturating accumulator and result capture into DONE.
  always_ff @(posedge Bclk or negedge reset) begin
    if (!reset) begin
      win_cnt     <= '0;
      acc         <= '0;
      overflow    <= 1'b0;
      count       <= '0;
      count_valid <= 1'b0;
    end else begin
      count_valid <= 1'b0;
      if (win_load) begin
        win_cnt  <= WIN_LAST;
        acc      <= '0;
        overflow <= 1'b0;
      end else if (state == MEASURE) begin
        acc <= acc_nxt;
        if (edge_pulse && (acc == ACC_MAX)) overflow <= 1'b1;
        if (win_cnt == '0) begin
          // Last measuring cycle: its own pulse is already folded into acc_nxt.
          count       <= acc_nxt;
          count_valid <= 1'b1;
        end else begin
          win_cnt <= win_cnt - WW'(1);
        end
      end
    end
  end

  assign idle_nxt = edge_pulse ? '0 :
                    (idle_cnt == STALL_N) ? idle_cnt : idle_cnt + IW'(1);

  // Stall watchdog, independent of the measurement FSM.
  always_ff @(posedge Bclk or negedge reset) begin
    if (!reset) begin
      idle_cnt <= '0;
      stalled  <= 1'b0;
    end else begin
      idle_cnt <= idle_nxt;
      stalled  <= (idle_nxt == STALL_N);
    end
  end

endmodule

// File: tb/tb_cdc_toggle_monitor.sv
// Bench for cdc_toggle_monitor: three instances (plain, narrow counter,
// continuous) share clock, reset and Din; expectations come from a Din
// history and window sums computed in the bench.
module tb_cdc_toggle_monitor;

  localparam int WA = 100, WB = 100, WC = 10;
  localparam int STA = 64, STC = 8;
  localparam int HMAX = 8192;

  logic Bclk = 1'b0, reset = 1'b0, Din = 1'b0;
  logic start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;
  logic ep_a, busy_a, cv_a, ovf_a, st_a;
  logic ep_b, busy_b, cv_b, ovf_b, st_b;
  logic ep_c, busy_c, cv_c, ovf_c, st_c;
  logic [15:0] cnt_a;
  logic [3:0]  cnt_b;
  logic [7:0]  cnt_c;

  int checks = 0, failures = 0;
  int k = 0;
  logic dh [HMAX];
  logic ph [HMAX];

  always #5 Bclk = ~Bclk;

  cdc_toggle_monitor #(.CNT_W(16), .WIN_CYCLES(WA), .STALL_CYCLES(STA), .CONTINUOUS(1'b0)) dut_a (
    .Bclk(Bclk), .reset(reset), .Din(Din), .start(start_a), .edge_pulse(ep_a), .busy(busy_a),
    .count(cnt_a), .count_valid(cv_a), .overflow(ovf_a), .stalled(st_a));
  cdc_toggle_monitor #(.CNT_W(4), .WIN_CYCLES(WB), .STALL_CYCLES(STA), .CONTINUOUS(1'b0)) dut_b (
    .Bclk(Bclk), .reset(reset), .Din(Din), .start(start_b), .edge_pulse(ep_b), .busy(busy_b),
    .count(cnt_b), .count_valid(cv_b), .overflow(ovf_b), .stalled(st_b));
  cdc_toggle_monitor #(.CNT_W(8), .WIN_CYCLES(WC), .STALL_CYCLES(STC), .CONTINUOUS(1'b1)) dut_c (
    .Bclk(Bclk), .reset(reset), .Din(Din), .start(start_c), .edge_pulse(ep_c), .busy(busy_c),
    .count(cnt_c), .count_valid(cv_c), .overflow(ovf_c), .stalled(st_c));

  // Reference: ph[j] = expected edge_pulse after edge j (edge 1 = first after release).
  function automatic int sum_p(input int lo, input int hi);
    int s = 0;
    for (int j = lo; j <= hi; j++) s += ph[j] ? 1 : 0;
    return s;
  endfunction

  function automatic int sat(input int v, input int w);
    int m = (1 << w) - 1;
    return (v > m) ? m : v;
  endfunction

  // Stalled after edge kk: at least st edges since release and no pulse in the last st cycles.
  function automatic logic exp_stall(input int kk, input int st);
    if (kk < st) return 1'b0;
    for (int j = kk - st; j < kk; j++) if (ph[j]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic tick(input logic d);
    Din = d;
    @(posedge Bclk);
    if (k < HMAX - 1) k++;
    else begin
      checks++; failures++;
      $display("FAIL history_bound k=%0d limit=%0d", k, HMAX - 1);
    end
    dh[k] = d;
    ph[k] = (k >= 2) && (dh[k] != dh[k-1]);
    #1;
  endtask

  task automatic release_reset();
    @(negedge Bclk);
    reset = 1'b1;
    k = 0; dh[0] = Din; ph[0] = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; Din = 1'b1;
    repeat (3) @(posedge Bclk);
    #1;
    checks++;
    if ({ep_a, busy_a, cv_a, ovf_a, st_a, cnt_a} !== 21'd0)
      begin failures++; $display("FAIL reset_outputs got=%h want=0", {ep_a, busy_a, cv_a, ovf_a, st_a, cnt_a}); end
    release_reset();
    for (int i = 0; i < STA + 4; i++) begin
      tick(1'b1);
      checks++;
      if (ep_a !== 1'b0) begin failures++; $display("FAIL t1_no_pulse k=%0d got=%b want=0", k, ep_a); end
      checks++;
      if (st_a !== exp_stall(k, STA)) begin failures++; $display("FAIL t1_stall_a k=%0d got=%b want=%b", k, st_a, exp_stall(k, STA)); end
      checks++;
      if (st_c !== exp_stall(k, STC)) begin failures++; $display("FAIL t1_stall_c k=%0d got=%b want=%b", k, st_c, exp_stall(k, STC)); end
    end
    checks++;
    if (cnt_a !== 16'd0) begin failures++; $display("FAIL t1_count got=%0d want=0", cnt_a); end
  endtask

  task automatic test_toggle4();
    logic d;
    int s, raw;
    d = ~Din;
    start_a = 1'b1; tick(d); start_a = 1'b0; s = k;
    checks++;
    if (busy_a !== 1'b1 || ovf_a !== 1'b0) begin failures++; $display("FAIL t2_start busy=%b ovf=%b want 1/0", busy_a, ovf_a); end
    for (int i = 1; i <= WA + 2; i++) begin
      if (i % 4 == 0) d = ~d;
      tick(d);
      checks++;
      if (ep_a !== ph[k]) begin failures++; $display("FAIL t2_pulse k=%0d got=%b want=%b", k, ep_a, ph[k]); end
      checks++;
      if (busy_a !== (k <= s + WA - 1)) begin failures++; $display("FAIL t2_busy k=%0d got=%b", k, busy_a); end
      checks++;
      if (cv_a !== (k == s + WA)) begin failures++; $display("FAIL t2_valid k=%0d got=%b", k, cv_a); end
      if (k == s + WA) begin
        raw = sum_p(s, s + WA - 1);
        checks++;
        if (cnt_a !== 16'(raw) || ovf_a !== 1'b0)
          begin failures++; $display("FAIL t2_count got=%0d ovf=%b want=%0d ovf=0", cnt_a, ovf_a, raw); end
      end
    end
  endtask

  task automatic test_saturate();
    logic d;
    int s, raw;
    d = ~Din;
    start_b = 1'b1; tick(d); start_b = 1'b0; s = k;
    raw = 0;
    for (int i = 1; i <= WB + 6; i++) begin
      d = ~d;
      tick(d);
      if (k == s + WB) begin
        raw = sum_p(s, s + WB - 1);
        checks++;
        if (cv_b !== 1'b1 || cnt_b !== 4'(sat(raw, 4)))
          begin failures++; $display("FAIL t3_count valid=%b got=%0d want=%0d", cv_b, cnt_b, sat(raw, 4)); end
        checks++;
        if (ovf_b !== (raw > 15)) begin failures++; $display("FAIL t3_ovf got=%b want=%b", ovf_b, raw > 15); end
      end else if (k > s + WB) begin
        checks++;
        if (ovf_b !== (raw > 15) || cnt_b !== 4'(sat(raw, 4)) || cv_b !== 1'b0)
          begin failures++; $display("FAIL t3_hold k=%0d ovf=%b cnt=%0d cv=%b", k, ovf_b, cnt_b, cv_b); end
      end
    end
    // Second window with Din held: overflow must clear on start and no events counted.
    start_b = 1'b1; tick(d); start_b = 1'b0; s = k;
    checks++;
    if (ovf_b !== 1'b0 || busy_b !== 1'b1) begin failures++; $display("FAIL t3_restart ovf=%b busy=%b want 0/1", ovf_b, busy_b); end
    for (int i = 1; i <= WB + 1; i++) begin
      tick(d);
      if (k == s + WB) begin
        raw = sum_p(s, s + WB - 1);
        checks++;
        if (cv_b !== 1'b1 || cnt_b !== 4'(sat(raw, 4)) || ovf_b !== 1'b0)
          begin failures++; $display("FAIL t3_quiet cv=%b cnt=%0d ovf=%b want 1/%0d/0", cv_b, cnt_b, ovf_b, sat(raw, 4)); end
      end
    end
  endtask

  task automatic test_stall();
    logic d;
    int gap;
    d = ~Din;
    tick(d);
    for (int i = 0; i < STA + 4; i++) begin
      tick(d);
      checks++;
      if (st_a !== exp_stall(k, STA)) begin failures++; $display("FAIL t4_stall_a k=%0d got=%b want=%b", k, st_a, exp_stall(k, STA)); end
    end
    d = ~d;
    for (int i = 0; i < 3; i++) begin
      tick(d);
      checks++;
      if (st_a !== exp_stall(k, STA)) begin failures++; $display("FAIL t4_unstall k=%0d got=%b want=%b", k, st_a, exp_stall(k, STA)); end
    end
    for (int r = 0; r < 12; r++) begin
      gap = $urandom_range(STC + 4, 1);
      d = ~d;
      for (int i = 0; i < gap; i++) begin
        tick(d);
        checks++;
        if (st_c !== exp_stall(k, STC)) begin failures++; $display("FAIL t4_stall_c k=%0d got=%b want=%b", k, st_c, exp_stall(k, STC)); end
        checks++;
        if (ep_c !== ph[k]) begin failures++; $display("FAIL t4_pulse_c k=%0d got=%b want=%b", k, ep_c, ph[k]); end
      end
    end
  endtask

  task automatic test_random_windows();
    logic d;
    int s, raw, thr;
    d = Din;
    for (int r = 0; r < 3; r++) begin
      thr = $urandom_range(100, 5);
      if ($urandom_range(99, 0) < thr) d = ~d;
      start_a = 1'b1; start_b = 1'b1; tick(d); start_a = 1'b0; start_b = 1'b0; s = k;
      for (int i = 1; i <= WA + 2; i++) begin
        if ($urandom_range(99, 0) < thr) d = ~d;
        tick(d);
        checks++;
        if (ep_a !== ph[k] || cv_a !== (k == s + WA))
          begin failures++; $display("FAIL rnd_cycle k=%0d pulse=%b cv=%b want %b/%b", k, ep_a, cv_a, ph[k], k == s + WA); end
        if (k == s + WA) begin
          raw = sum_p(s, s + WA - 1);
          checks++;
          if (cnt_a !== 16'(sat(raw, 16)) || ovf_a !== (raw > 65535))
            begin failures++; $display("FAIL rnd_count_a got=%0d ovf=%b want=%0d", cnt_a, ovf_a, raw); end
          checks++;
          if (cv_b !== 1'b1 || cnt_b !== 4'(sat(raw, 4)) || ovf_b !== (raw > 15))
            begin failures++; $display("FAIL rnd_count_b got=%0d ovf=%b want=%0d ovf=%b", cnt_b, ovf_b, sat(raw, 4), raw > 15); end
        end
      end
    end
  endtask

  task automatic test_restart_and_reset();
    logic d;
    int s, raw, nvalid;
    d = Din;
    start_a = 1'b1; tick(d); start_a = 1'b0; s = k; nvalid = 0;
    for (int i = 1; i <= WA + 4; i++) begin
      start_a = (i <= WA + 1) && ($urandom_range(3, 0) == 0);
      if ($urandom_range(1, 0) == 1) d = ~d;
      tick(d);
      if (cv_a === 1'b1) nvalid++;
      if (k == s + WA) begin
        raw = sum_p(s, s + WA - 1);
        checks++;
        if (cv_a !== 1'b1 || cnt_a !== 16'(raw))
          begin failures++; $display("FAIL t5_count cv=%b got=%0d want=%0d", cv_a, cnt_a, raw); end
      end
    end
    start_a = 1'b0;
    checks++;
    if (nvalid !== 1) begin failures++; $display("FAIL t5_single_valid got=%0d want=1", nvalid); end
    checks++;
    if (busy_a !== 1'b0) begin failures++; $display("FAIL t5_idle busy=%b want=0", busy_a); end
    // Abort a window with an asynchronous reset.
    start_a = 1'b1; tick(d); start_a = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(1, 0) == 1) d = ~d;
      tick(d);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (busy_a !== 1'b0 || cnt_a !== 16'd0 || cv_a !== 1'b0 || ovf_a !== 1'b0 || st_a !== 1'b0)
      begin failures++; $display("FAIL t5_async_reset busy=%b cnt=%0d cv=%b ovf=%b st=%b want all 0", busy_a, cnt_a, cv_a, ovf_a, st_a); end
    for (int i = 0; i < 4; i++) begin
      @(posedge Bclk); #1;
      checks++;
      if (cv_a !== 1'b0 || busy_a !== 1'b0) begin failures++; $display("FAIL t5_in_reset cv=%b busy=%b want 0/0", cv_a, busy_a); end
    end
    release_reset();
    start_a = 1'b1; tick(d); start_a = 1'b0; s = k; nvalid = 0;
    for (int i = 1; i <= WA + 2; i++) begin
      if ($urandom_range(2, 0) == 0) d = ~d;
      tick(d);
      if (cv_a === 1'b1) nvalid++;
      if (k == s + WA) begin
        raw = sum_p(s, s + WA - 1);
        checks++;
        if (cv_a !== 1'b1 || cnt_a !== 16'(raw))
          begin failures++; $display("FAIL t5_after_reset cv=%b got=%0d want=%0d", cv_a, cnt_a, raw); end
      end
    end
    checks++;
    if (nvalid !== 1) begin failures++; $display("FAIL t5_after_reset_valids got=%0d want=1", nvalid); end
  endtask

  task automatic test_continuous();
    logic d;
    int s, raw, ph_pos;
    d = ~Din;
    start_c = 1'b1; tick(d); start_c = 1'b0; s = k;
    for (int i = 1; i <= 7 * (WC + 1); i++) begin
      if (i <= 4 * (WC + 1)) begin
        if (i % 2 == 0) d = ~d;
      end else if ($urandom_range(1, 0) == 1) begin
        d = ~d;
      end
      tick(d);
      ph_pos = (k - s) % (WC + 1);
      checks++;
      if (busy_c !== (ph_pos != WC)) begin failures++; $display("FAIL t6_busy k=%0d got=%b", k, busy_c); end
      checks++;
      if (cv_c !== (ph_pos == WC)) begin failures++; $display("FAIL t6_valid k=%0d got=%b", k, cv_c); end
      if (ph_pos == WC) begin
        raw = sum_p(k - WC, k - 1);
        checks++;
        if (cnt_c !== 8'(raw) || ovf_c !== 1'b0)
          begin failures++; $display("FAIL t6_count k=%0d got=%0d ovf=%b want=%0d", k, cnt_c, ovf_c, raw); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_toggle4();
    test_saturate();
    test_stall();
    test_random_windows();
    test_restart_and_reset();
    test_continuous();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog time=%0t limit=1000000", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
